// File: rtl/dmem_wait_server_if.sv
// dmem_wait_server_if: DMem request/response handshake between core memory stage and data-memory server
interface dmem_wait_server_if;
  logic        request__ENA;
  logic [31:0] request_write_en;
  logic [31:0] request_addr;
  logic [31:0] request_data;
  logic        request__RDY;
  logic [31:0] response;
  logic        response__RDY;
  logic        response__ENA;
  modport master (
    output request__ENA, request_write_en, request_addr, request_data, response__ENA,
    input  request__RDY, response, response__RDY
  );
  modport slave (
    input  request__ENA, request_write_en, request_addr, request_data, response__ENA,
    output request__RDY, response, response__RDY
  );
endinterface

// File: rtl/dmem_wait_server.sv
// dmem_wait_server: single-slot data-memory server with LATENCY wait states; `define DMEM_BOUNDS_CHECK_EN to trap out-of-range byte addresses
module dmem_wait_server #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input logic CLK,
  input logic nRST,
  dmem_wait_server_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e        state_q;
  logic [3:0]    cnt_q;
  logic          wr_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   data_q;
  logic [31:0]   resp_q;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_d;
  logic          access;
  logic          wr_commit;
  logic [31:0]   rd_word;
  assign idx_d  = bus.request_addr[AW+1:2];
  assign access = (state_q == WAIT) && (cnt_q == 4'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
  logic oob_q;
  logic oob_d;
  assign oob_d     = bus.request_addr >= 32'(DEPTH) * 32'd4;
  assign wr_commit = wr_q & ~oob_q;
  assign rd_word   = oob_q ? 32'hDEADBEEF : mem[idx_q];
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) oob_q <= 1'b0;
    else if (state_q == IDLE && bus.request__ENA) oob_q <= oob_d;
`else
  logic unused_addr;
  assign unused_addr = ^{bus.request_addr[31:AW+2], bus.request_addr[1:0]};
  assign wr_commit   = wr_q;
  assign rd_word     = mem[idx_q];
`endif
  assign bus.request__RDY  = state_q == IDLE;
  assign bus.response__RDY = state_q == RESP;
  assign bus.response      = resp_q;
  always_ff @(posedge CLK)
    if (access && wr_commit) mem[idx_q] <= data_q;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      data_q  <= 32'h0;
      resp_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: if (bus.request__ENA) begin
          wr_q    <= |bus.request_write_en;
          idx_q   <= idx_d;
          data_q  <= bus.request_data;
          cnt_q   <= 4'(LATENCY);
          state_q <= WAIT;
        end
        WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        else begin
          if (!wr_q) resp_q <= rd_word;
          state_q <= wr_q ? IDLE : RESP;
        end
        RESP: if (bus.response__ENA) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
